pipelined_mux_tree: RTL and testbench

- Registered N:1 selector for WIDTH-bit lanes, built as a binary tree of 2:1 cells.
- Default configuration is a 4:1 single-bit mux: data_out = data_in[sel].
- Used as the generic selection primitive in datapath and register-file read paths.
- Optional register after every tree level trades latency for timing; a valid bit travels alongside the data.

---
 rtl/mux_tree_pkg.sv | 19 +
 rtl/mux2_cell.sv | 13 +
 rtl/pipelined_mux_tree.sv | 114 +++++++++++
 tb/tb_pipelined_mux_tree.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mux_tree_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined mux tree.
package mux_tree_pkg;

    localparam int DEF_N     = 4;
    localparam int DEF_WIDTH = 1;

    // Number of 2:1 levels needed to reduce n lanes to one.
    function automatic int levels(input int n);
        return $clog2(n);
    endfunction

    // Tree nodes use heap numbering: node 1 is the root, node k has children
    // 2k and 2k+1, and leaves sit at N..2N-1. A node's tree level counts
    // from the leaves, so the nodes fed directly by leaves are level 0.
    function automatic int node_level(input int node, input int lvls);
        return lvls - $clog2(node + 1);
    endfunction

endpackage

// File: rtl/mux2_cell.sv
// Plain 2:1 selector cell: y = a when s is 0, b when s is 1.
module mux2_cell #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? b : a;

endmodule

// File: rtl/pipelined_mux_tree.sv
// Registered N:1 lane selector built from a binary tree of mux2_cell.
// PIPELINE=0: whole tree is combinational, result registered once (latency 1).
// PIPELINE=1: a register bank follows every tree level (latency levels(N)).
//
// Valid semantics: in_valid qualifies data_in and sel on the same rising
// edge. There is no ready; every sample is accepted and out_valid pulses
// exactly latency cycles later, and the consumer must take it. Stages advance
// every cycle regardless of in_valid, so data_out keeps following the tree.
module pipelined_mux_tree
    import mux_tree_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PIPELINE = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [N*WIDTH-1:0]     data_in,
    input  logic [$clog2(N)-1:0]   sel,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       data_out
);

    localparam int L = levels(N);

    // Cell outputs indexed by heap node number (1 = root).
    logic [WIDTH-1:0] w_cell    [1:N-1];
    // Value each parent sees for node k: a data lane for leaves, otherwise
    // the child cell output either directly or through its stage register.
    logic [WIDTH-1:0] w_src     [2:2*N-1];
    // The sel vector belonging to the sample currently at each level.
    logic [L-1:0]     w_sel_lvl [0:L-1];

    genvar k;
    genvar n;
    genvar j;

    for (k = 0; k < N; k++) begin : g_leaf
        assign w_src[N+k] = data_in[k*WIDTH +: WIDTH];
    end

    for (n = 1; n < N; n++) begin : g_cell
        localparam int LV = node_level(n, L);
        mux2_cell #(.WIDTH(WIDTH)) u_cell (
            .a (w_src[2*n]),
            .b (w_src[2*n+1]),
            .s (w_sel_lvl[LV][LV]),
            .y (w_cell[n])
        );
    end

    if (PIPELINE != 0) begin : g_pipe
        logic [WIDTH-1:0] r_cell [1:N-1];
        logic [L-1:0]     r_sel  [0:L-1];
        logic             r_vld  [0:L-1];

        // Later levels read their operands from the previous level's bank.
        for (n = 2; n < N; n++) begin : g_src
            assign w_src[n] = r_cell[n];
        end

        // sel travels with the data so each level uses its own sample's bit.
        assign w_sel_lvl[0] = sel;
        for (j = 1; j < L; j++) begin : g_sel
            assign w_sel_lvl[j] = r_sel[j-1];
        end

        // One register bank per level for data, sel and valid.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int c = 1; c < N; c++) r_cell[c] <= '0;
                for (int s = 0; s < L; s++) begin
                    r_sel[s] <= '0;
                    r_vld[s] <= 1'b0;
                end
            end else begin
                for (int c = 1; c < N; c++) r_cell[c] <= w_cell[c];
                r_vld[0] <= in_valid;
                for (int s = 0; s < L; s++) r_sel[s] <= w_sel_lvl[s];
                for (int s = 1; s < L; s++) r_vld[s] <= r_vld[s-1];
            end
        end

        assign data_out  = r_cell[1];
        assign out_valid = r_vld[L-1];
    end else begin : g_comb
        logic [WIDTH-1:0] r_data;
        logic             r_vld;

        for (n = 2; n < N; n++) begin : g_src
            assign w_src[n] = w_cell[n];
        end

        for (j = 0; j < L; j++) begin : g_sel
            assign w_sel_lvl[j] = sel;
        end

        // Single output register behind the combinational tree.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_data <= '0;
                r_vld  <= 1'b0;
            end else begin
                r_data <= w_cell[1];
                r_vld  <= in_valid;
            end
        end

        assign data_out  = r_data;
        assign out_valid = r_vld;
    end

endmodule

// File: tb/tb_pipelined_mux_tree.sv
// Directed bench for pipelined_mux_tree: three configurations share one clock
// and reset (4:1x1 combinational, 4:1x8 combinational, 8:1x4 pipelined).
module tb_pipelined_mux_tree;

    logic clk;
    logic reset;

    // Instance A: N=4, WIDTH=1, PIPELINE=0
    logic        a_vld;
    logic [3:0]  a_data;
    logic [1:0]  a_sel;
    logic        a_ov;
    logic [0:0]  a_dout;

    // Instance B: N=4, WIDTH=8, PIPELINE=0
    logic        b_vld;
    logic [31:0] b_data;
    logic [1:0]  b_sel;
    logic        b_ov;
    logic [7:0]  b_dout;

    // Instance C: N=8, WIDTH=4, PIPELINE=1
    logic        c_vld;
    logic [31:0] c_data;
    logic [2:0]  c_sel;
    logic        c_ov;
    logic [3:0]  c_dout;

    int checks = 0;
    int errors = 0;

    pipelined_mux_tree #(.N(4), .WIDTH(1), .PIPELINE(0)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_vld), .data_in(a_data),
        .sel(a_sel), .out_valid(a_ov), .data_out(a_dout)
    );

    pipelined_mux_tree #(.N(4), .WIDTH(8), .PIPELINE(0)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_vld), .data_in(b_data),
        .sel(b_sel), .out_valid(b_ov), .data_out(b_dout)
    );

    pipelined_mux_tree #(.N(8), .WIDTH(4), .PIPELINE(1)) u_c (
        .clk(clk), .reset(reset), .in_valid(c_vld), .data_in(c_data),
        .sel(c_sel), .out_valid(c_ov), .data_out(c_dout)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] dv;
    logic [7:0] b_exp [4];

    initial begin
        reset  = 1'b1;
        a_vld  = 1'b0; a_data = '0; a_sel = '0;
        b_vld  = 1'b0; b_data = '0; b_sel = '0;
        c_vld  = 1'b0; c_data = '0; c_sel = '0;

        // Reset state
        tick();
        tick();
        check("rst_a_ov",   a_ov,   1'b0);
        check("rst_a_dout", a_dout, 1'b0);
        check("rst_b_ov",   b_ov,   1'b0);
        check("rst_b_dout", b_dout, 8'h00);
        check("rst_c_ov",   c_ov,   1'b0);
        check("rst_c_dout", c_dout, 4'h0);
        reset = 1'b0;

        // Exhaustive 4:1 single bit, latency 1
        for (int d = 0; d < 16; d++) begin
            for (int s = 0; s < 4; s++) begin
                dv     = d[3:0];
                a_data = dv;
                a_sel  = s[1:0];
                a_vld  = 1'b1;
                tick();
                check($sformatf("exh_d%0h_s%0d", d, s), a_dout, dv[s]);
                check($sformatf("exh_ov_d%0h_s%0d", d, s), a_ov, 1'b1);
            end
        end

        // Hand-computed spot checks: 4'b0100
        a_data = 4'b0100; a_sel = 2'd2; tick();
        check("spot_0100_s2", a_dout, 1'b1);
        a_sel = 2'd1; tick();
        check("spot_0100_s1", a_dout, 1'b0);
        a_vld = 1'b0; tick();
        check("a_ov_drop", a_ov, 1'b0);

        // Back-to-back streaming on 8-bit lanes
        b_exp[0] = 8'hAA; b_exp[1] = 8'hBB; b_exp[2] = 8'hCC; b_exp[3] = 8'hDD;
        b_data = 32'hDDCCBBAA;
        b_vld  = 1'b1;
        for (int s = 0; s < 4; s++) begin
            b_sel = s[1:0];
            tick();
            check($sformatf("stream_s%0d", s), b_dout, b_exp[s]);
            check($sformatf("stream_ov_s%0d", s), b_ov, 1'b1);
        end

        // Lane isolation
        b_data = 32'h00FF0000;
        b_sel = 2'd2; tick(); check("iso_s2", b_dout, 8'hFF);
        b_sel = 2'd1; tick(); check("iso_s1", b_dout, 8'h00);
        b_sel = 2'd3; tick(); check("iso_s3", b_dout, 8'h00);

        // Valid gap 1,0,1 with inputs held across the gap
        b_data = 32'h44332211;
        b_sel = 2'd1; b_vld = 1'b1; tick();
        check("gap_ov0", b_ov, 1'b1);   check("gap_d0", b_dout, 8'h22);
        b_vld = 1'b0; tick();
        check("gap_ov1", b_ov, 1'b0);   check("gap_d1", b_dout, 8'h22);
        b_sel = 2'd2; b_vld = 1'b1; tick();
        check("gap_ov2", b_ov, 1'b1);   check("gap_d2", b_dout, 8'h33);
        b_vld = 1'b0;

        // Pipelined 8:1, latency 3: lanes hold 0..7
        c_data = 32'h76543210;
        c_sel = 3'd5; c_vld = 1'b1; tick();
        check("p_e1_ov", c_ov, 1'b0);   check("p_e1_d", c_dout, 4'h0);
        c_sel = 3'd2; tick();
        check("p_e2_ov", c_ov, 1'b0);   check("p_e2_d", c_dout, 4'h0);
        c_sel = 3'd0; c_vld = 1'b0; tick();
        check("p_e3_ov", c_ov, 1'b1);   check("p_e3_d", c_dout, 4'h5);
        tick();
        check("p_e4_ov", c_ov, 1'b1);   check("p_e4_d", c_dout, 4'h2);
        tick();
        check("p_e5_ov", c_ov, 1'b0);

        // Reset with two samples in flight
        c_sel = 3'd7; c_vld = 1'b1; tick();
        c_sel = 3'd3; tick();
        c_sel = 3'd6; reset = 1'b1; tick();
        check("flush_ov", c_ov, 1'b0);  check("flush_d", c_dout, 4'h0);
        reset = 1'b0;
        c_sel = 3'd4; c_vld = 1'b1; tick();
        check("post_e1_ov", c_ov, 1'b0); check("post_e1_d", c_dout, 4'h0);
        c_vld = 1'b0; tick();
        check("post_e2_ov", c_ov, 1'b0); check("post_e2_d", c_dout, 4'h0);
        tick();
        check("post_e3_ov", c_ov, 1'b1); check("post_e3_d", c_dout, 4'h4);
        tick();
        check("post_e4_ov", c_ov, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
